// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with byte-enable writes, busy scoreboard and a
// sequenced clear engine. Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
    output logic [NUM_RD-1:0]          o_rd_busy,
    input  logic                       i_wen,
    input  logic [ADDR_W-1:0]          i_wreg,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [DATA_W/8-1:0]        i_wbe,
    input  logic                       i_lock_en,
    input  logic [ADDR_W-1:0]          i_lock_reg,
    input  logic                       i_clr,
    output logic                       o_ready
);

    localparam int DEPTH    = 1 << ADDR_W;
    localparam int NBYTES   = DATA_W / 8;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                ready;
    logic                wr_ok;
    logic                lock_ok;
    logic [DATA_W-1:0]   wr_old;
    logic [DATA_W-1:0]   wr_merged;

    assign ready   = (state_q == ST_READY);
    assign wr_ok   = ready && i_wen && !(HAS_ZERO && (i_wreg == '0));
    assign lock_ok = ready && i_lock_en && !(HAS_ZERO && (i_lock_reg == '0));
    assign o_ready = ready;

    // Byte-merged write word: enabled bytes from i_wdata, the rest from the stored entry.
    assign wr_old = mem[i_wreg];
    always_comb begin
        wr_merged = wr_old;
        for (int b = 0; b < NBYTES; b++) begin
            if (i_wbe[b]) begin
                wr_merged[8*b +: 8] = i_wdata[8*b +: 8];
            end
        end
    end

    // NOTE: every signal driven here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (i_clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = '0;
                end else begin
                    // Lock is applied after the write so it wins on the same register.
                    if (wr_ok) begin
                        busy_d[i_wreg] = 1'b0;
                    end
                    if (lock_ok) begin
                        busy_d[i_lock_reg] = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: the array has no reset; the clear engine zeroes it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (wr_ok) begin
            mem[i_wreg] <= wr_merged;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = i_rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            o_rd_data[k*DATA_W +: DATA_W] = '0;
            o_rd_busy[k]                  = 1'b0;
            if (ready && !(HAS_ZERO && (ra == '0))) begin
                o_rd_data[k*DATA_W +: DATA_W] = mem[ra];
                o_rd_busy[k]                  = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
                // Forward the in-flight write so decode sees it without a stall.
                if (wr_ok && (ra == i_wreg)) begin
                    o_rd_data[k*DATA_W +: DATA_W] = wr_merged;
                    o_rd_busy[k]                  = lock_ok && (i_lock_reg == i_wreg);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp (32x32, 3 read ports, ZERO_REG = 1).
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic [14:0]  i_rd_addr;
    logic [95:0]  o_rd_data;
    logic [2:0]   o_rd_busy;
    logic         i_wen;
    logic [4:0]   i_wreg;
    logic [31:0]  i_wdata;
    logic [3:0]   i_wbe;
    logic         i_lock_en;
    logic [4:0]   i_lock_reg;
    logic         i_clr;
    logic         o_ready;

    int checks = 0;
    int errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_busy  (o_rd_busy),
        .i_wen      (i_wen),
        .i_wreg     (i_wreg),
        .i_wdata    (i_wdata),
        .i_wbe      (i_wbe),
        .i_lock_en  (i_lock_en),
        .i_lock_reg (i_lock_reg),
        .i_clr      (i_clr),
        .o_ready    (o_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wen;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic        lock_en;
        logic [4:0]  lock_reg;
        logic [14:0] ra;
        logic [95:0] ed;
        logic [2:0]  eb;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t v(input logic wen, input logic [4:0] wreg, input logic [31:0] wdata,
                               input logic [3:0] wbe, input logic lock_en, input logic [4:0] lock_reg,
                               input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                               input logic b0, input logic b1, input logic b2);
        vec_t r;
        r.wen = wen; r.wreg = wreg; r.wdata = wdata; r.wbe = wbe;
        r.lock_en = lock_en; r.lock_reg = lock_reg;
        r.ra = {a2, a1, a0};
        r.ed = {d2, d1, d0};
        r.eb = {b2, b1, b0};
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_wen = 1'b0; i_wreg = '0; i_wdata = '0; i_wbe = '0;
        i_lock_en = 1'b0; i_lock_reg = '0; i_clr = 1'b0;
    endtask

    // Holds inputs steady for DEPTH edges, checking the block stays in CLEAR, then checks READY.
    task automatic sweep(input string name);
        for (int c = 0; c < 32; c++) begin
            #1;
            check({name, "_clearing"}, {o_ready, o_rd_busy, o_rd_data}, '0);
            tick();
        end
        idle();
        #1;
        check({name, "_ready"}, o_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        i_rd_addr = {5'd3, 5'd2, 5'd1};

        vecs[0]  = v(1, 5, 32'hFFFF_FFFF, 4'hF, 0, 0,  0, 6, 7,  0, 0, 0,  0, 0, 0);
        vecs[1]  = v(1, 5, 32'h1234_5678, 4'h5, 0, 0,  1, 2, 3,  0, 0, 0,  0, 0, 0);
        vecs[2]  = v(0, 0, 0, 0, 0, 0,  5, 5, 0,  32'hFF34_FF78, 32'hFF34_FF78, 0,  0, 0, 0);
        vecs[3]  = v(1, 0, 32'hDEAD_BEEF, 4'hF, 1, 0,  5, 1, 2,  32'hFF34_FF78, 0, 0,  0, 0, 0);
        vecs[4]  = v(0, 0, 0, 0, 1, 7,  0, 0, 9,  0, 0, 0,  0, 0, 0);
        vecs[5]  = v(0, 0, 0, 0, 0, 0,  7, 0, 0,  0, 0, 0,  1, 0, 0);
        vecs[6]  = v(1, 7, 32'h0000_00A5, 4'hF, 0, 0,  1, 2, 3,  0, 0, 0,  0, 0, 0);
        vecs[7]  = v(1, 9, 32'h0000_CAFE, 4'hF, 1, 9,  7, 1, 2,  32'hA5, 0, 0,  0, 0, 0);
        vecs[8]  = v(0, 0, 0, 0, 0, 0,  9, 7, 5,  32'hCAFE, 32'hA5, 32'hFF34_FF78,  1, 0, 0);
        vecs[9]  = v(1, 10, 32'h33, 4'hF, 1, 11,  12, 13, 14,  0, 0, 0,  0, 0, 0);
        vecs[10] = v(1, 6, 32'h0000_FFFF, 4'h0, 0, 0,  10, 11, 0,  32'h33, 0, 0,  0, 1, 0);
        vecs[11] = v(1, 5, 32'hAB00_0000, 4'h8, 0, 0,  6, 3, 4,  0, 0, 0,  0, 0, 0);
        vecs[12] = v(0, 0, 0, 0, 0, 0,  5, 6, 11,  32'hAB34_FF78, 0, 0,  0, 0, 1);

        // Reset state and initial sweep.
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", o_ready, 0);
        check("reset_data", o_rd_data, 0);
        check("reset_busy", o_rd_busy, 0);
        rst = 1'b0;
        sweep("init");
        check("init_data", o_rd_data, 0);

        // Directed vector table: outputs are checked before the edge that commits the row.
        for (int i = 0; i < 13; i++) begin
            i_wen = vecs[i].wen; i_wreg = vecs[i].wreg; i_wdata = vecs[i].wdata;
            i_wbe = vecs[i].wbe; i_lock_en = vecs[i].lock_en; i_lock_reg = vecs[i].lock_reg;
            i_rd_addr = vecs[i].ra;
            #1;
            check($sformatf("vec%0d_data", i), o_rd_data, vecs[i].ed);
            check($sformatf("vec%0d_busy", i), o_rd_busy, vecs[i].eb);
            check($sformatf("vec%0d_ready", i), o_ready, 1);
            tick();
            idle();
        end

        // Same-cycle write/read of r4 on port 0, then lock+write on port 1.
        i_wen = 1; i_wreg = 4; i_wdata = 32'h11; i_wbe = 4'hF;
        i_rd_addr = {5'd0, 5'd0, 5'd4};
        #1;
        check("byp_wr_data", o_rd_data[31:0], BYP ? 32'h11 : 32'h0);
        check("byp_wr_busy", o_rd_busy[0], 0);
        tick();
        idle();
        #1;
        check("byp_wr_after", o_rd_data[31:0], 32'h11);
        i_wen = 1; i_wreg = 4; i_wdata = 32'h22; i_wbe = 4'h3; i_lock_en = 1; i_lock_reg = 4;
        i_rd_addr = {5'd0, 5'd4, 5'd0};
        #1;
        check("byp_lk_data", o_rd_data[63:32], BYP ? 32'h22 : 32'h11);
        check("byp_lk_busy", o_rd_busy[1], BYP ? 1 : 0);
        tick();
        idle();
        #1;
        check("byp_lk_after_data", o_rd_data[63:32], 32'h22);
        check("byp_lk_after_busy", o_rd_busy[1], 1);

        // Clear mid-operation: fill r1..r31, lock r3, sweep while writes/locks are attempted.
        for (int r = 1; r < 32; r++) begin
            i_wen = 1; i_wreg = 5'(r); i_wdata = 32'h0101_0101 * r; i_wbe = 4'hF;
            tick();
        end
        idle();
        i_lock_en = 1; i_lock_reg = 3;
        tick();
        idle();
        i_rd_addr = {5'd3, 5'd2, 5'd1};
        #1;
        check("fill_data", o_rd_data, {32'h0303_0303, 32'h0202_0202, 32'h0101_0101});
        check("fill_busy", o_rd_busy, 3'b100);
        i_clr = 1;
        tick();
        i_clr = 1; i_wen = 1; i_wreg = 1; i_wdata = 32'hFFFF_FFFF; i_wbe = 4'hF;
        i_lock_en = 1; i_lock_reg = 3;
        sweep("clr");
        for (int g = 0; g < 11; g++) begin
            i_rd_addr = {5'(3*g + 3), 5'(3*g + 2), 5'(3*g + 1)};
            #1;
            check($sformatf("clr_rd%0d", g), {o_rd_busy, o_rd_data}, '0);
        end

        // Reset at sweep cycle 10 restarts the full sweep.
        i_wen = 1; i_wreg = 2; i_wdata = 32'h55; i_wbe = 4'hF;
        tick();
        idle();
        i_clr = 1;
        tick();
        idle();
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("midrst_ready", o_ready, 0);
        tick();
        rst = 1'b0;
        sweep("midrst");
        i_rd_addr = {5'd0, 5'd0, 5'd2};
        #1;
        check("midrst_r2", o_rd_data[31:0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
